// File: rtl/operand_tf_result_serializer.sv
// Width converter for the operand transformer: captures one full result vector and
// drains it to the consumer as narrow beats of LANES elements, lowest elements first.
module operand_tf_result_serializer #(
    parameter int unsigned ELEM_W    = 16,
    parameter int unsigned NUM_ELEM  = 32,
    parameter int unsigned LANES     = 4,
    localparam int unsigned BEATS     = NUM_ELEM / LANES,
    localparam int unsigned BEAT_W    = $clog2(BEATS),
    localparam int unsigned BEAT_BITS = LANES * ELEM_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_ELEM*ELEM_W-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BEAT_BITS-1:0]         out_data,
    output logic                         out_last,
    output logic [BEAT_W-1:0]            out_beat_idx,
    output logic [15:0]                  vec_cnt,
    output logic                         busy
);

    typedef enum logic {StIdle, StSend} state_e;

    localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BEATS - 1);

    state_e                             state_q;
    logic [BEAT_W-1:0]                  beat_q;
    // One row per output beat, so a beat is a plain row select.
    logic [BEATS-1:0][BEAT_BITS-1:0]    buf_q;
    logic [15:0]                        vec_cnt_q;

    logic last_beat;
    logic beat_done;
    logic accept;

    assign last_beat = (state_q == StSend) && (beat_q == LastBeat);
    // Releasing the producer in the final-beat cycle is what gives back-to-back vectors.
    assign in_ready  = (state_q == StIdle) | (last_beat & out_ready);
    assign accept    = in_valid & in_ready;
    assign beat_done = (state_q == StSend) & out_ready;

    assign out_valid    = (state_q == StSend);
    assign busy         = (state_q == StSend);
    assign out_last     = last_beat;
    assign out_data     = buf_q[beat_q];
    assign out_beat_idx = beat_q;
    assign vec_cnt      = vec_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            buf_q     <= '0;
            vec_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        buf_q   <= in_data;
                        beat_q  <= '0;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (beat_done) begin
                        if (last_beat) begin
                            vec_cnt_q <= vec_cnt_q + 16'd1;
                            beat_q    <= '0;
                            if (accept) begin
                                buf_q <= in_data;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/operand_tf_result_serializer.md
# operand_tf_result_serializer

Output stage placed directly downstream of the operand transformer. It accepts one complete result vector (NUM_ELEM elements, presented in parallel from the transformer's temporal registers) through a valid/ready handshake. It then drains the vector as BEATS = NUM_ELEM/LANES narrow beats of LANES elements each, using a second valid/ready handshake toward the consumer. It releases the transformer as soon as the vector is captured, and supports back-to-back vectors with no idle cycle.

## Interface
- ELEM_W, 16, bits per result element
- NUM_ELEM, 32, elements per result vector (must be a multiple of LANES)
- LANES, 4, elements per output beat; BEATS = NUM_ELEM/LANES, must be ≥ 2
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  result vector available (driven by transformer valid_out)
- in_ready  output  1  serializer accepts vector this cycle (drives transformer ready_out)
- in_data  input  NUM_ELEM*ELEM_W  element e at in_data[e*ELEM_W +: ELEM_W]
- out_valid  output  1  beat valid
- out_ready  input  1  consumer accepts beat
- out_data  output  LANES*ELEM_W  lane l = element (beat_idx*LANES + l)
- out_last  output  1  high on the final beat (beat_idx == BEATS-1) while out_valid
- out_beat_idx  output  $clog2(BEATS)  index of current beat
- vec_cnt  output  16  count of fully drained vectors, wraps at 2^16
- busy  output  1  high in SEND

## Operation
- States: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, capture in_data into the internal buffer, set beat=0, and go to SEND.
- SEND:
  - out_valid=1, and out_data is the buffer slice for the current beat.
  - On out_ready with beat<BEATS-1: beat increments.
  - On out_ready with beat==BEATS-1: vec_cnt increments (wraps 0xFFFF→0). Then:
    - if in_valid, capture the new vector and set beat=0, staying in SEND;
    - otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==SEND & beat==BEATS-1 & out_ready). This is a combinational path from out_ready to in_ready and is intended.
- While out_valid & !out_ready, the buffer, beat, out_data, out_last and out_beat_idx stay stable.
- The buffer is written only on an accepted input (in_valid & in_ready). in_data is ignored otherwise.
- No reordering: element index order is preserved exactly.

## Timing
- Reset (asynchronous, any state including mid-vector):
  - state=IDLE, beat=0, buffer=0, vec_cnt=0.
  - Outputs: out_valid=0, out_last=0, out_beat_idx=0, busy=0, out_data=0, in_ready=1.
  - A partially sent vector is discarded.
- Latency: input accepted at edge t → beat 0 has out_valid=1 in the cycle after t.
- Throughput: with out_ready held high, one vector every BEATS cycles. Back-to-back vectors have no bubble.
- out_valid never deasserts without an accepted beat, except on reset.
- in_valid arriving during SEND while beat<BEATS-1 is held off (in_ready=0). The upstream producer must hold it.
- out_ready asserted in IDLE has no effect.

## Test plan
- **Reset values:** hold rst_n=0 → in_ready=1, out_valid=0, vec_cnt=0. Release, and drive in_data with element e = 16'h0100+e and a one-cycle in_valid → 8 beats. Beat 0 out_data = {0x0103,0x0102,0x0101,0x0100}; beat 7 = {0x011F..0x011C} with out_last=1. Afterwards vec_cnt=1 and the block returns to IDLE.
- **Backpressure:** out_ready low for 5 cycles during beat 3 → out_data stays {0x010F..0x010C} and out_beat_idx stays 3. Draining then resumes with no lost or duplicated beat.
- **Back-to-back vectors:** in_valid held high with two vectors (0x01xx, then 0x02xx) and out_ready=1 → in_ready pulses in the beat-7 cycle. The next cycle shows beat 0 = {0x0203..0x0200}. Total 16 consecutive valid beats, vec_cnt=2.
- **Input hold-off:** in_valid asserted at beat 2 → in_ready=0 until the beat-7 handshake, and the buffer is unchanged.
- **Reset mid-vector:** assert rst_n=0 at beat 4 → out_valid drops immediately, vec_cnt=0. After release, the next vector starts at beat 0.
- **vec_cnt wrap:** drain 65536 vectors (or force vec_cnt to 0xFFFF) → after one more vector, vec_cnt=0.
